// File: rtl/pitch_frac_search_pkg.sv
// Shared pitch-search constants and the sequencer state encoding.
// Imported by the fractional pitch sequencer and its interpolator port bundle.
package pitch_frac_search_pkg;
    localparam int LAG_LIMIT = 84;
    localparam int FRAC_MIN  = -2;
    localparam int FRAC_MAX  = 2;
    localparam int UP_SAMP   = 3;

    typedef logic [2:0] state_t;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_ADJUST = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic signed [15:0] MAX_INIT = 16'sh8000;
endpackage

// File: rtl/pitch_frac_search_if.sv
// Port bundle between the fractional pitch sequencer and the shared 1/3 interpolator.
// Handshake: the master pulses interp_start for one cycle with interp_x/interp_frac and holds
// them until the slave pulses interp_done; interp_result is valid only while interp_done=1.
interface pitch_frac_search_if;
    logic               interp_start;
    logic [11:0]        interp_x;
    logic signed [15:0] interp_frac;
    logic               interp_done;
    logic signed [15:0] interp_result;

    modport master (
        output interp_start,
        output interp_x,
        output interp_frac,
        input  interp_done,
        input  interp_result
    );

    modport slave (
        input  interp_start,
        input  interp_x,
        input  interp_frac,
        output interp_done,
        output interp_result
    );
endinterface

// File: rtl/pitch_frac_search.sv
// G.729 Pitch_fr3 sequencer: runs the interpolator for each fraction around t0,
// keeps the strict maximum and returns the lag/fraction in the {-1,0,1} form.
module pitch_frac_search #(
    parameter int LAG_LIMIT = pitch_frac_search_pkg::LAG_LIMIT,
    parameter int FRAC_MIN  = pitch_frac_search_pkg::FRAC_MIN,
    parameter int FRAC_MAX  = pitch_frac_search_pkg::FRAC_MAX
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic signed [15:0]  t0,
    input  logic [11:0]         corr_addr,
    input  logic                first_subfr,
    pitch_frac_search_if.master interp,
    output logic signed [15:0]  t0_out,
    output logic signed [15:0]  frac_out,
    output logic                done,
    output logic [2:0]          state_dbg
);
    import pitch_frac_search_pkg::state_t;
    import pitch_frac_search_pkg::S_IDLE;
    import pitch_frac_search_pkg::S_LAUNCH;
    import pitch_frac_search_pkg::S_WAIT;
    import pitch_frac_search_pkg::S_ADJUST;
    import pitch_frac_search_pkg::S_DONE;
    import pitch_frac_search_pkg::MAX_INIT;

    localparam logic signed [15:0] FMIN = 16'(FRAC_MIN);
    localparam logic signed [15:0] FMAX = 16'(FRAC_MAX);
    localparam logic signed [15:0] LIM  = 16'(LAG_LIMIT);

    state_t             state;
    logic signed [15:0] t0_q;
    logic [11:0]        addr_q;
    logic signed [15:0] cur_frac;
    logic signed [15:0] max_q;
    logic signed [15:0] best_frac;

    // x/frac stay on the bus through WAIT since the interpolator samples them late.
    assign interp.interp_start = (state == S_LAUNCH);
    assign interp.interp_x     = addr_q;
    assign interp.interp_frac  = cur_frac;
    assign done                = (state == S_DONE);
    assign state_dbg           = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            t0_q      <= '0;
            addr_q    <= '0;
            cur_frac  <= '0;
            max_q     <= '0;
            best_frac <= '0;
            t0_out    <= '0;
            frac_out  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        t0_q <= t0;
                        if (first_subfr && (t0 > LIM)) begin
                            // Early exit reuses ADJUST with a zero fraction to land done two cycles out.
                            best_frac <= '0;
                            t0_out    <= t0;
                            frac_out  <= '0;
                            state     <= S_ADJUST;
                        end else begin
                            addr_q    <= corr_addr;
                            cur_frac  <= FMIN;
                            max_q     <= MAX_INIT;
                            best_frac <= FMIN;
                            state     <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: state <= S_WAIT;
                S_WAIT: begin
                    if (interp.interp_done) begin
                        if (interp.interp_result > max_q) begin
                            max_q     <= interp.interp_result;
                            best_frac <= cur_frac;
                        end
                        if (cur_frac == FMAX) begin
                            state <= S_ADJUST;
                        end else begin
                            cur_frac <= cur_frac + 16'sd1;
                            state    <= S_LAUNCH;
                        end
                    end
                end
                S_ADJUST: begin
                    if (best_frac == FMIN) begin
                        t0_out   <= t0_q - 16'sd1;
                        frac_out <= 16'sd1;
                    end else if (best_frac == FMAX) begin
                        t0_out   <= t0_q + 16'sd1;
                        frac_out <= -16'sd1;
                    end else begin
                        t0_out   <= t0_q;
                        frac_out <= best_frac;
                    end
                    state <= S_DONE;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
